// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO block: register offsets,
// STATUS bit layout and the default MMIO window select.
package dmem_mmio_pkg;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_CYCLE  = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam int STAT_OVF    = 7;
  localparam int STAT_FULL   = 6;
  localparam int STAT_EMPTY  = 5;
  localparam int STAT_CNT_HI = 4;

  localparam logic [3:0] MMIO_BASE_DEF = 4'hF;

  typedef enum logic {
    REGION_RAM  = 1'b0,
    REGION_MMIO = 1'b1
  } region_e;

  // Count field is only 5 bits wide, so deeper FIFOs report 31 when fuller.
  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [31:0] cnt);
    logic [31:0] word;
    word = '0;
    word[STAT_OVF]         = ovf;
    word[STAT_FULL]        = full;
    word[STAT_EMPTY]       = empty;
    word[STAT_CNT_HI:0]    = (cnt > 32'd31) ? 5'd31 : cnt[4:0];
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO window with
// LED, cycle counter and a TX byte FIFO. Reads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] MMIO_BASE  = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        addr_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       mem [1 << ADDR_W];
  logic [31:0]       cycle_cnt;
  logic              overflow;
  logic              aligned;
  logic              rd_en;
  logic              wr_en;
  logic              misaligned;
  region_e           region;
  logic [7:0]        off;
  logic [ADDR_W-1:0] ram_idx;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              led_we;
  logic              cycle_we;
  logic              status_we;
  logic              unused_addr;

  assign aligned    = (addr[1:0] == 2'b00);
  assign rd_en      = DM_CS && DM_R && aligned;
  assign wr_en      = DM_CS && DM_W && aligned;
  assign misaligned = DM_CS && (DM_R || DM_W) && !aligned;
  assign region     = (addr[31:28] == MMIO_BASE) ? REGION_MMIO : REGION_RAM;
  assign off        = addr[7:0];
  assign ram_idx    = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[27:8];

  assign led_we    = wr_en && (region == REGION_MMIO) && (off == OFF_LED);
  assign cycle_we  = wr_en && (region == REGION_MMIO) && (off == OFF_CYCLE);
  assign fifo_push = wr_en && (region == REGION_MMIO) && (off == OFF_TXDATA);
  assign status_we = wr_en && (region == REGION_MMIO) && (off == OFF_STATUS);

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (wr_en && region == REGION_RAM) mem[ram_idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out   <= '0;
      cycle_cnt <= '0;
      overflow  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      addr_err <= misaligned;
      if (led_we) led_out <= wdata[15:0];
      cycle_cnt <= cycle_we ? 32'd0 : cycle_cnt + 32'd1;
      // A dropped push in the same cycle as a STATUS write keeps the flag set.
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (status_we)                      overflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (region == REGION_MMIO) begin
        case (off)
          OFF_LED:    rdata = {16'b0, led_out};
          OFF_CYCLE:  rdata = cycle_cnt;
          OFF_STATUS: rdata = pack_status(overflow, fifo_full, fifo_empty, 32'(fifo_count));
          default:    rdata = '0;
        endcase
      end else begin
        rdata = mem[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, LED, misalignment, cycle counter,
// TX FIFO fill/overflow/drain and asynchronous reset.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        DM_CS, DM_R, DM_W;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [15:0] led_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .DM_CS    (DM_CS),
    .DM_R     (DM_R),
    .DM_W     (DM_W),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .led_out  (led_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .addr_err (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    DM_CS = cs; DM_R = r; DM_W = w; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    reset    = 1'b0;
    tx_ready = 1'b0;
    idle();
    #1;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rdata_cs0", rdata, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("rst_status", rdata, 32'h0000_0020);
    idle();
    reset = 1'b1;

    // Cycle counter after 100 edges
    repeat (100) tick();
    drive(1'b1, 1'b1, 1'b0, 32'hF0000004, 32'h0);
    #1;
    chk("cycle_100", rdata, 32'd100);
    drive(1'b1, 1'b0, 1'b1, 32'hF0000004, 32'h1234);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hF0000004, 32'h0);
    #1;
    chk("cycle_clr", rdata, 32'd0);
    tick();
    chk("cycle_after_clr", rdata, 32'd1);

    // RAM, alias and read-during-write
    drive(1'b1, 1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h00000010, 32'h0);
    #1;
    chk("ram_rd", rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 32'h00001010, 32'h0);
    #1;
    chk("ram_alias", rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b0, 32'h00000010, 32'h0);
    #1;
    chk("ram_r0", rdata, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h00000010, 32'h11111111);
    #1;
    chk("ram_rw_old", rdata, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h00000010, 32'h0);
    #1;
    chk("ram_rw_new", rdata, 32'h11111111);

    // LED and misalignment
    drive(1'b1, 1'b0, 1'b1, 32'hF0000000, 32'h1234ABCD);
    tick();
    chk("led_out", 32'(led_out), 32'h0000ABCD);
    drive(1'b1, 1'b1, 1'b0, 32'hF0000000, 32'h0);
    #1;
    chk("led_rd", rdata, 32'h0000ABCD);
    drive(1'b1, 1'b0, 1'b1, 32'hF0000002, 32'h00005555);
    tick();
    chk("mis_err_set", 32'(addr_err), 32'h1);
    chk("mis_led_keep", 32'(led_out), 32'h0000ABCD);
    idle();
    tick();
    chk("mis_err_clr", 32'(addr_err), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h00000012, 32'h0);
    #1;
    chk("mis_rd_zero", rdata, 32'h0);
    tick();
    chk("mis_rd_err", 32'(addr_err), 32'h1);

    // FIFO fill past full
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hF0000008, 32'(i));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("status_ovf", rdata, 32'h0000_00C8);
    chk("head_01", 32'(tx_data), 32'h01);
    drive(1'b1, 1'b1, 1'b0, 32'hF0000008, 32'h0);
    #1;
    chk("txdata_rd0", rdata, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'hF000000C, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("status_clr", rdata, 32'h0000_0048);

    // Push while full with a pop in the same cycle
    drive(1'b1, 1'b0, 1'b1, 32'hF0000008, 32'h0000000A);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("status_pushpop", rdata, 32'h0000_0048);

    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(tx_data), 32'(drain_exp[i]));
      tick();
    end
    tx_ready = 1'b0;
    chk("drained_valid", 32'(tx_valid), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("drained_status", rdata, 32'h0000_0020);

    // Push and pop at count 1
    drive(1'b1, 1'b0, 1'b1, 32'hF0000008, 32'h00000033);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hF0000008, 32'h00000044);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("c1_head", 32'(tx_data), 32'h44);
    chk("c1_valid", 32'(tx_valid), 32'h1);
    chk("c1_status", rdata, 32'h0000_0021 & 32'h0000_001F);

    // Asynchronous reset between clock edges
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'h0);
    chk("arst_led", 32'(led_out), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0);
    #1;
    chk("arst_status", rdata, 32'h0000_0020);
    drive(1'b1, 1'b1, 1'b0, 32'hF0000004, 32'h0);
    #1;
    chk("arst_cycle", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
